modn_updown_counter: RTL

- Parametrised synchronous modulo-N up/down counter; successor to the fixed mod-16 T-flip-flop ripple counter.
- Fully synchronous single-clock design; adds direction control, parallel load, synchronous clear, wrap or saturate mode, and terminal-count / wrap flags.
- Used as a building block for timers, dividers and cascaded counter chains; chaining is done via `en` ← upstream `tc`.

---
 rtl/counter_pkg.sv | 30 +++
 rtl/modn_next_state.sv | 77 +++++++
 rtl/modn_updown_counter.sv | 101 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N up/down counter family.
// Optional Gray output is enabled in the top by MODN_COUNTER_GRAY_OUT_EN.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  // Widest counter the Gray helper can encode.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bits needed to hold the values 0..m-1.
  function automatic int clog2_mod(input int m);
    return (m <= 1) ? 0 : $clog2(m);
  endfunction

  function automatic int mod_max(input int m);
    return m - 1;
  endfunction

  function automatic bit modulus_ok(input int w, input int m);
    return (w >= 1) && (m >= 2) && (clog2_mod(m) <= w);
  endfunction

endpackage

// File: rtl/modn_next_state.sv
// Combinational next count, wrap and load-error for the modulo-N counter.
// Zero latency; no flow control, priority is clr > load > en.
module modn_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q_d,
  output logic             wrap_d,
  output logic             load_err_d
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(mod_max(MODULUS));
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  cnt_dir_e         dir;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_top;
  logic             at_bottom;
  logic             load_oor;

  assign dir     = cnt_dir_e'(up);
  // One extra bit keeps MODULUS = 2^WIDTH representable.
  assign q_ext   = {1'b0, q};
  assign inc_ext = q_ext + ONE_EXT;
  assign dec_ext = q_ext - ONE_EXT;

  assign at_top    = (inc_ext == MOD_EXT);
  assign at_bottom = dec_ext[WIDTH];
  assign load_oor  = ({1'b0, load_val} >= MOD_EXT);

  always_comb begin
    q_d        = q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      q_d = RST_VAL;
    end else if (load) begin
      if (load_oor) begin
        q_d        = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        q_d = load_val;
      end
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (!at_top) begin
          q_d = inc_ext[WIDTH-1:0];
        end else if (SATURATE == 0) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          q_d = dec_ext[WIDTH-1:0];
        end else if (SATURATE == 0) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate and cascade tc; q one clock after request.
// No backpressure; MODN_COUNTER_GRAY_OUT_EN adds a registered Gray image q_gray.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef MODN_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(mod_max(MODULUS));
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS must lie in 2..2^WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("modn_updown_counter: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  modn_next_state #(
    .WIDTH     (WIDTH),
    .MODULUS   (MODULUS),
    .RESET_VAL (RESET_VAL),
    .SATURATE  (SATURATE)
  ) u_next (
    .q          (q_q),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .clr        (clr),
    .q_d        (q_d),
    .wrap_d     (wrap_d),
    .load_err_d (load_err_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= RST_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

  // Deliberately ungated by load/clr so a cascade sees a stable enable.
  assign tc = en & ((up & (q_q == MAX_VAL)) | (~up & (q_q == '0)));

`ifdef MODN_COUNTER_GRAY_OUT_EN
  if (WIDTH > GRAY_MAX_W) begin : g_bad_gray_width
    $error("modn_updown_counter: WIDTH too large for Gray output");
  end

  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RESET_VAL)));

  logic [WIDTH-1:0] q_gray_q, q_gray_d;

  // Encoded from the next state so the Gray image never lags q.
  assign q_gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(q_d)));

  always_ff @(posedge clk) begin
    if (rst) begin
      q_gray_q <= RST_GRAY;
    end else begin
      q_gray_q <= q_gray_d;
    end
  end

  assign q_gray = q_gray_q;
`endif

endmodule
